// File: rtl/modport_alu.sv
// rtl/modport_alu.sv - registered parameterised ALU with arithmetic/logical command sets
// Single-cycle ops land on the next edge; multiplies take one extra edge and freeze the inputs meanwhile.
module modport_alu #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic         MODE,
    input  logic [M-1:0] CMD,
    input  logic [1:0]   INP_VALID,
    input  logic [N-1:0] OPA,
    input  logic [N-1:0] OPB,
    input  logic         CIN,
    output logic [N:0]   RES,
    output logic         COUT,
    output logic         OFLOW,
    output logic         G,
    output logic         L,
    output logic         E,
    output logic         ERR
);

    localparam int SW = $clog2(N);

    localparam logic [M-1:0] C_0  = M'(0);
    localparam logic [M-1:0] C_1  = M'(1);
    localparam logic [M-1:0] C_2  = M'(2);
    localparam logic [M-1:0] C_3  = M'(3);
    localparam logic [M-1:0] C_4  = M'(4);
    localparam logic [M-1:0] C_5  = M'(5);
    localparam logic [M-1:0] C_6  = M'(6);
    localparam logic [M-1:0] C_7  = M'(7);
    localparam logic [M-1:0] C_8  = M'(8);
    localparam logic [M-1:0] C_9  = M'(9);
    localparam logic [M-1:0] C_10 = M'(10);
    localparam logic [M-1:0] C_11 = M'(11);
    localparam logic [M-1:0] C_12 = M'(12);
    localparam logic [M-1:0] C_13 = M'(13);

    logic [N:0]    res_q, res_d;
    logic          cout_q, cout_d;
    logic          oflow_q, oflow_d;
    logic          g_q, g_d;
    logic          l_q, l_d;
    logic          e_q, e_d;
    logic          err_q, err_d;
    logic          mul_pend_q, mul_pend_d;
    logic [N:0]    mul_fa_q, mul_fa_d;
    logic [N:0]    mul_fb_q, mul_fb_d;

    logic [N:0]    a_ext, b_ext, cin_ext, one_ext;
    logic [SW-1:0] rot_amt;
    logic          rot_bad;
    logic [N-1:0]  rol, ror;
    logic          need_a, need_b, cmd_ok, ops_ok;

    always_comb begin
        a_ext   = {1'b0, OPA};
        b_ext   = {1'b0, OPB};
        cin_ext = {{N{1'b0}}, CIN};
        one_ext = {{N{1'b0}}, 1'b1};
        rot_amt = OPB[SW-1:0];
        rot_bad = (OPB >> SW) != '0;
        rol     = (OPA << rot_amt) | (OPA >> (N - int'(rot_amt)));
        ror     = (OPA >> rot_amt) | (OPA << (N - int'(rot_amt)));
    end

    // Operand requirements per command; an undefined command needs nothing but is rejected.
    always_comb begin
        need_a = 1'b0;
        need_b = 1'b0;
        cmd_ok = 1'b1;
        if (MODE) begin
            case (CMD)
                C_0, C_1, C_2, C_3, C_8, C_9, C_10: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                end
                C_4, C_5: need_a = 1'b1;
                C_6, C_7: need_b = 1'b1;
                default:  cmd_ok = 1'b0;
            endcase
        end else begin
            case (CMD)
                C_0, C_1, C_2, C_3, C_4, C_5, C_12, C_13: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                end
                C_6, C_8, C_9:   need_a = 1'b1;
                C_7, C_10, C_11: need_b = 1'b1;
                default:         cmd_ok = 1'b0;
            endcase
        end
        ops_ok = !(need_a && !INP_VALID[0]) && !(need_b && !INP_VALID[1]);
    end

    always_comb begin
        res_d      = res_q;
        cout_d     = cout_q;
        oflow_d    = oflow_q;
        g_d        = g_q;
        l_d        = l_q;
        e_d        = e_q;
        err_d      = err_q;
        mul_pend_d = mul_pend_q;
        mul_fa_d   = mul_fa_q;
        mul_fb_d   = mul_fb_q;
        if (CE) begin
            res_d      = '0;
            cout_d     = 1'b0;
            oflow_d    = 1'b0;
            g_d        = 1'b0;
            l_d        = 1'b0;
            e_d        = 1'b0;
            err_d      = 1'b0;
            mul_pend_d = 1'b0;
            if (mul_pend_q) begin
                res_d = mul_fa_q * mul_fb_q;
            end else if (!cmd_ok || !ops_ok) begin
                err_d = 1'b1;
            end else if (MODE) begin
                case (CMD)
                    C_0: begin
                        res_d  = a_ext + b_ext;
                        cout_d = res_d[N];
                    end
                    C_1: begin
                        res_d   = a_ext - b_ext;
                        oflow_d = a_ext < b_ext;
                    end
                    C_2: begin
                        res_d  = a_ext + b_ext + cin_ext;
                        cout_d = res_d[N];
                    end
                    C_3: begin
                        res_d   = a_ext - b_ext - cin_ext;
                        oflow_d = a_ext < (b_ext + cin_ext);
                    end
                    C_4: begin
                        res_d  = a_ext + one_ext;
                        cout_d = res_d[N];
                    end
                    C_5: begin
                        res_d   = a_ext - one_ext;
                        oflow_d = OPA == '0;
                    end
                    C_6: begin
                        res_d  = b_ext + one_ext;
                        cout_d = res_d[N];
                    end
                    C_7: begin
                        res_d   = b_ext - one_ext;
                        oflow_d = OPB == '0;
                    end
                    C_8: begin
                        g_d = OPA > OPB;
                        l_d = OPA < OPB;
                        e_d = OPA == OPB;
                    end
                    C_9, C_10: begin
                        // Outputs freeze while the operands wait one edge for the product.
                        {res_d, cout_d, oflow_d, g_d, l_d, e_d, err_d} =
                            {res_q, cout_q, oflow_q, g_q, l_q, e_q, err_q};
                        mul_pend_d = 1'b1;
                        mul_fa_d   = (CMD == C_9) ? a_ext + one_ext : {OPA, 1'b0};
                        mul_fb_d   = (CMD == C_9) ? b_ext + one_ext : b_ext;
                    end
                    default: err_d = 1'b1;
                endcase
            end else begin
                case (CMD)
                    C_0:  res_d = {1'b0, OPA & OPB};
                    C_1:  res_d = {1'b0, ~(OPA & OPB)};
                    C_2:  res_d = {1'b0, OPA | OPB};
                    C_3:  res_d = {1'b0, ~(OPA | OPB)};
                    C_4:  res_d = {1'b0, OPA ^ OPB};
                    C_5:  res_d = {1'b0, ~(OPA ^ OPB)};
                    C_6:  res_d = {1'b0, ~OPA};
                    C_7:  res_d = {1'b0, ~OPB};
                    C_8:  res_d = {1'b0, OPA >> 1};
                    C_9:  res_d = {1'b0, OPA << 1};
                    C_10: res_d = {1'b0, OPB >> 1};
                    C_11: res_d = {1'b0, OPB << 1};
                    C_12: begin
                        if (rot_bad) err_d = 1'b1;
                        else         res_d = {1'b0, rol};
                    end
                    C_13: begin
                        if (rot_bad) err_d = 1'b1;
                        else         res_d = {1'b0, ror};
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            res_q      <= '0;
            cout_q     <= 1'b0;
            oflow_q    <= 1'b0;
            g_q        <= 1'b0;
            l_q        <= 1'b0;
            e_q        <= 1'b0;
            err_q      <= 1'b0;
            mul_pend_q <= 1'b0;
            mul_fa_q   <= '0;
            mul_fb_q   <= '0;
        end else begin
            res_q      <= res_d;
            cout_q     <= cout_d;
            oflow_q    <= oflow_d;
            g_q        <= g_d;
            l_q        <= l_d;
            e_q        <= e_d;
            err_q      <= err_d;
            mul_pend_q <= mul_pend_d;
            mul_fa_q   <= mul_fa_d;
            mul_fb_q   <= mul_fb_d;
        end
    end

    assign RES   = res_q;
    assign COUT  = cout_q;
    assign OFLOW = oflow_q;
    assign G     = g_q;
    assign L     = l_q;
    assign E     = e_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_modport_alu.sv
// tb/tb_modport_alu.sv - self-checking bench for modport_alu
module tb_modport_alu;

    logic       CLK = 1'b0;
    logic       RST, CE, MODE, CIN;
    logic [3:0] CMD;
    logic [1:0] INP_VALID;
    logic [7:0] OPA, OPB;
    logic [8:0] RES;
    logic       COUT, OFLOW, G, L, E, ERR;

    int total = 0;
    int bad   = 0;

    logic [14:0] exp_q;
    bit          pend;
    logic [14:0] pend_val;
    wire  [14:0] obs = {RES, COUT, OFLOW, G, L, E, ERR};

    modport_alu #(.N(8), .M(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
        .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Returns {accepted_multiply, res[8:0], cout, oflow, g, l, e, err}.
    function automatic logic [15:0] ref_op(input bit mode, input int cmd, input logic [1:0] iv,
                                           input int a, input int b, input int c);
        int r = 0;
        bit co = 0, ov = 0, gg = 0, ll = 0, ee = 0, er = 0, mul = 0;
        bit na = 0, nb = 0, undef = 0;
        if (mode) begin
            if (cmd <= 3 || (cmd >= 8 && cmd <= 10)) begin na = 1; nb = 1; end
            else if (cmd == 4 || cmd == 5) na = 1;
            else if (cmd == 6 || cmd == 7) nb = 1;
            else undef = 1;
        end else begin
            if (cmd <= 5 || cmd == 12 || cmd == 13) begin na = 1; nb = 1; end
            else if (cmd == 6 || cmd == 8 || cmd == 9) na = 1;
            else if (cmd == 7 || cmd == 10 || cmd == 11) nb = 1;
            else undef = 1;
        end
        if (undef || (na && !iv[0]) || (nb && !iv[1])) er = 1;
        else if (mode) begin
            case (cmd)
                0:  begin r = a + b;     co = r > 255; end
                1:  begin r = a - b;     ov = r < 0;   end
                2:  begin r = a + b + c; co = r > 255; end
                3:  begin r = a - b - c; ov = r < 0;   end
                4:  begin r = a + 1;     co = r > 255; end
                5:  begin r = a - 1;     ov = r < 0;   end
                6:  begin r = b + 1;     co = r > 255; end
                7:  begin r = b - 1;     ov = r < 0;   end
                8:  begin gg = a > b; ll = a < b; ee = a == b; end
                9:  begin r = (a + 1) * (b + 1); mul = 1; end
                10: begin r = a * 2 * b;         mul = 1; end
                default: ;
            endcase
        end else begin
            case (cmd)
                0:  r = a & b;
                1:  r = ~(a & b) & 255;
                2:  r = a | b;
                3:  r = ~(a | b) & 255;
                4:  r = a ^ b;
                5:  r = ~(a ^ b) & 255;
                6:  r = ~a & 255;
                7:  r = ~b & 255;
                8:  r = a >> 1;
                9:  r = (a << 1) & 255;
                10: r = b >> 1;
                11: r = (b << 1) & 255;
                12: if (b > 7) er = 1; else r = ((a << b) | (a >> (8 - b))) & 255;
                13: if (b > 7) er = 1; else r = ((a >> b) | (a << (8 - b))) & 255;
                default: ;
            endcase
        end
        return {mul, 9'(r & 511), co, ov, gg, ll, ee, er};
    endfunction

    task automatic tick();
        logic [15:0] r;
        @(posedge CLK);
        if (!RST) begin
            exp_q = '0;
            pend  = 0;
        end else if (CE) begin
            if (pend) begin
                exp_q = pend_val;
                pend  = 0;
            end else begin
                r = ref_op(MODE, int'(CMD), INP_VALID, int'(OPA), int'(OPB), int'(CIN));
                if (r[15]) begin
                    pend     = 1;
                    pend_val = r[14:0];
                end else begin
                    exp_q = r[14:0];
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit mode, input logic [3:0] cmd, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input bit c);
        RST = 1'b1; CE = 1'b1; MODE = mode; CMD = cmd; INP_VALID = iv;
        OPA = a; OPB = b; CIN = c;
    endtask

    typedef struct packed {
        bit          mode;
        logic [3:0]  cmd;
        logic [1:0]  iv;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          cin;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs [17] = '{
        '{1'b1, 4'd0,  2'b11, 8'hFF, 8'h01, 1'b0, {9'h100, 6'b100000}},
        '{1'b1, 4'd1,  2'b11, 8'h03, 8'h05, 1'b0, {9'h1FE, 6'b010000}},
        '{1'b1, 4'd8,  2'b11, 8'h05, 8'h05, 1'b0, {9'h000, 6'b000010}},
        '{1'b1, 4'd8,  2'b11, 8'h09, 8'h05, 1'b0, {9'h000, 6'b001000}},
        '{1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0, {9'h003, 6'b000000}},
        '{1'b0, 4'd12, 2'b11, 8'h81, 8'h10, 1'b0, {9'h000, 6'b000001}},
        '{1'b0, 4'd0,  2'b01, 8'h3C, 8'h0F, 1'b0, {9'h000, 6'b000001}},
        '{1'b0, 4'd15, 2'b11, 8'h3C, 8'h0F, 1'b0, {9'h000, 6'b000001}},
        '{1'b1, 4'd5,  2'b01, 8'h00, 8'h00, 1'b0, {9'h1FF, 6'b010000}},
        '{1'b1, 4'd4,  2'b01, 8'hFF, 8'h00, 1'b0, {9'h100, 6'b100000}},
        '{1'b1, 4'd6,  2'b01, 8'h10, 8'h20, 1'b0, {9'h000, 6'b000001}},
        '{1'b1, 4'd3,  2'b11, 8'h05, 8'h02, 1'b1, {9'h002, 6'b000000}},
        '{1'b1, 4'd2,  2'b11, 8'h80, 8'h7F, 1'b1, {9'h100, 6'b100000}},
        '{1'b1, 4'd11, 2'b11, 8'h01, 8'h01, 1'b0, {9'h000, 6'b000001}},
        '{1'b0, 4'd7,  2'b10, 8'hAA, 8'h0F, 1'b0, {9'h0F0, 6'b000000}},
        '{1'b0, 4'd13, 2'b11, 8'h01, 8'h01, 1'b0, {9'h080, 6'b000000}},
        '{1'b1, 4'd4,  2'b00, 8'h01, 8'h01, 1'b0, {9'h000, 6'b000001}}
    };

    task automatic test_reset();
        RST = 1'b0; CE = 1'b1; MODE = 1'b1; CMD = 4'd0; INP_VALID = 2'b11;
        OPA = 8'hFF; OPB = 8'h01; CIN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== 15'h0) begin
                bad++;
                $display("FAIL reset[%0d]: got %h want %h", i, obs, 15'h0);
            end
        end
        RST = 1'b1; CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            OPA = 8'($urandom); OPB = 8'($urandom); CMD = 4'($urandom);
            tick();
            total++;
            if (obs !== 15'h0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, 15'h0);
            end
        end
    endtask

    task automatic test_directed();
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].cmd, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].cin);
            tick();
            total++;
            if (obs !== vecs[i].exp) begin
                bad++;
                $display("FAIL directed[%0d]: got %h want %h", i, obs, vecs[i].exp);
            end
        end
    endtask

    task automatic test_ce_hold();
        drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
        tick();
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MODE = 1'($urandom); CMD = 4'($urandom); OPA = 8'($urandom); OPB = 8'($urandom);
            tick();
            total++;
            if (obs !== {9'h100, 6'b100000}) begin
                bad++;
                $display("FAIL ce_hold[%0d]: got %h want %h", i, obs, {9'h100, 6'b100000});
            end
        end
    endtask

    task automatic test_mul_latency();
        drive(1'b1, 4'd8, 2'b11, 8'h05, 8'h05, 1'b0);
        tick();
        drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h03, 1'b0);
        tick();
        total++;
        if (obs !== {9'h000, 6'b000010}) begin
            bad++;
            $display("FAIL mul_first_edge: got %h want %h", obs, {9'h000, 6'b000010});
        end
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0);
        tick();
        total++;
        if (obs !== {9'h00C, 6'b000000}) begin
            bad++;
            $display("FAIL mul_product: got %h want %h", obs, {9'h00C, 6'b000000});
        end
        drive(1'b1, 4'd10, 2'b11, 8'h90, 8'h03, 1'b0);
        tick();
        tick();
        total++;
        if (obs !== {9'h160, 6'b000000}) begin
            bad++;
            $display("FAIL mul_shift_trunc: got %h want %h", obs, {9'h160, 6'b000000});
        end
        drive(1'b1, 4'd9, 2'b01, 8'h02, 8'h03, 1'b0);
        tick();
        total++;
        if (obs !== {9'h000, 6'b000001}) begin
            bad++;
            $display("FAIL mul_invalid: got %h want %h", obs, {9'h000, 6'b000001});
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h03, 1'b0);
        tick();
        drive(1'b1, 4'd10, 2'b11, 8'h03, 8'h05, 1'b0);
        tick();
        total++;
        if (obs !== {9'h00C, 6'b000000}) begin
            bad++;
            $display("FAIL b2b_land: got %h want %h", obs, {9'h00C, 6'b000000});
        end
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0);
        tick();
        total++;
        if (obs !== {9'h003, 6'b000000}) begin
            bad++;
            $display("FAIL b2b_ignored: got %h want %h", obs, {9'h003, 6'b000000});
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h03, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        total++;
        if (obs !== 15'h0) begin
            bad++;
            $display("FAIL abort_reset: got %h want %h", obs, 15'h0);
        end
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0);
        tick();
        total++;
        if (obs !== {9'h002, 6'b000000}) begin
            bad++;
            $display("FAIL abort_no_product: got %h want %h", obs, {9'h002, 6'b000000});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            RST       = ($urandom_range(0, 49) != 0);
            CE        = ($urandom_range(0, 9) != 0);
            MODE      = 1'($urandom);
            CMD       = 4'($urandom);
            INP_VALID = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            OPA       = 8'($urandom);
            OPB       = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            CIN       = 1'($urandom);
            tick();
            total++;
            if (obs !== exp_q) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_q);
            end
        end
    endtask

    initial begin
        exp_q = '0;
        pend  = 0;
        pend_val = '0;
        RST = 1'b0; CE = 1'b0; MODE = 1'b0; CMD = '0; INP_VALID = '0;
        OPA = '0; OPB = '0; CIN = 1'b0;
        test_reset();
        test_directed();
        test_ce_hold();
        test_mul_latency();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
